dmem_responder: RTL

Word-organised data-memory responder serving the core's load/store port over a valid/ready request/response handshake. It accepts one access at a time, waits a configurable number of cycles, then performs a byte-, half- or word-sized read or write and returns sign- or zero-extended load data. It sits between the core's memory stage and the physical data-memory array, and replaces the single-cycle DMEM model when multi-cycle memory timing must be exercised.

---
 rtl/dmem_resp_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 71 +++++++
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // The reserved encoding 2'b11 behaves as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for one access: store byte-enable/merge, load extract/extend, misalign detect.
// DMEM_RESP_MISALIGN_CHK_EN: flag misaligned half/word accesses instead of forcing alignment.
module dmem_lane_align
   import dmem_resp_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [1:0]  lane;
   logic [31:0] wrep;
   logic [31:0] shifted;

   always_comb begin
      misalign = 1'b0;
      lane     = addr_lo;
`ifdef DMEM_RESP_MISALIGN_CHK_EN
      if (is_word(size)) begin
         misalign = (addr_lo != 2'b00);
      end else if (size == SIZE_HALF) begin
         misalign = addr_lo[0];
      end
`else
      if (is_word(size)) begin
         lane = 2'b00;
      end else if (size == SIZE_HALF) begin
         lane = {addr_lo[1], 1'b0};
      end
`endif

      byte_en = 4'b0001 << lane;
      wrep    = {4{wdata[7:0]}};
      if (is_word(size)) begin
         byte_en = '1;
         wrep    = wdata;
      end else if (size == SIZE_HALF) begin
         byte_en = lane[1] ? 4'b1100 : 4'b0011;
         wrep    = {2{wdata[15:0]}};
      end
      if (misalign) begin
         byte_en = '0;
      end

      wword = rword;
      for (int unsigned i = 0; i < 4; i++) begin
         if (byte_en[i]) begin
            wword[8*i +: 8] = wrep[8*i +: 8];
         end
      end

      shifted = rword >> {lane, 3'b000};
      if (is_word(size)) begin
         rdata = rword;
      end else if (size == SIZE_HALF) begin
         rdata = {{16{sign & shifted[15]}}, shifted[15:0]};
      end else begin
         rdata = {{24{sign & shifted[7]}}, shifted[7:0]};
      end
      if (misalign) begin
         rdata = '0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle word-organised data memory behind a valid/ready load/store port.
// DMEM_RESP_MISALIGN_CHK_EN (in dmem_lane_align) turns misaligned accesses into RSP_ERR responses.
module dmem_responder
   import dmem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [1:0]  REQ_BYTE_SEL,
   input  logic        REQ_SIGN,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          cur_we;
   logic [AW+1:0] cur_addr;
   logic [1:0]    cur_size;
   logic          cur_sign;
   logic [31:0]   cur_wdata;
   logic [31:0]   rword;
   logic [3:0]    byte_en;
   logic [31:0]   wword;
   logic [31:0]   ld_data;
   logic          misalign;
   logic          commit;
   logic          mem_we;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^REQ_ADDR[31:AW+2];

   // With no wait states the access commits on the accepting edge, so use the live request.
   always_comb begin
      if (state_q == IDLE) begin
         cur_we    = REQ_WE;
         cur_addr  = REQ_ADDR[AW+1:0];
         cur_size  = REQ_BYTE_SEL;
         cur_sign  = REQ_SIGN;
         cur_wdata = REQ_WDATA;
      end else begin
         cur_we    = we_q;
         cur_addr  = addr_q;
         cur_size  = size_q;
         cur_sign  = sign_q;
         cur_wdata = wdata_q;
      end
   end

   assign rword = mem[cur_addr[AW+1:2]];

   dmem_lane_align u_lane_align (
      .size     (cur_size),
      .addr_lo  (cur_addr[1:0]),
      .sign     (cur_sign),
      .wdata    (cur_wdata),
      .rword    (rword),
      .byte_en  (byte_en),
      .wword    (wword),
      .rdata    (ld_data),
      .misalign (misalign)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      size_d      = size_q;
      sign_d      = sign_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      commit      = 1'b0;

      case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               we_d    = REQ_WE;
               addr_d  = REQ_ADDR[AW+1:0];
               size_d  = REQ_BYTE_SEL;
               sign_d  = REQ_SIGN;
               wdata_d = REQ_WDATA;
               cnt_d   = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               cnt_d   = '0;
               commit  = 1'b1;
            end
         end
         RESP: begin
            // The first RESP cycle registers the committed result; RSP_VALID follows one edge later.
            rsp_valid_d = 1'b1;
            if (rsp_valid_q && RSP_READY) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit) begin
         rsp_rdata_d = cur_we ? '0 : ld_data;
         rsp_err_d   = misalign;
      end
      mem_we = commit & cur_we & ~misalign & RST;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         size_q      <= SIZE_WORD;
         sign_q      <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Array contents survive reset; a store committed before reset stays.
   always_ff @(posedge CLK) begin
      if (mem_we && (byte_en != 4'b0000)) begin
         mem[cur_addr[AW+1:2]] <= wword;
      end
   end

   assign REQ_READY = (state_q == IDLE) & RST;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;

endmodule
